ai_emotion_analyzer_param: RTL

- Parametrised next-generation melodic emotion classifier: circular note window of DEPTH entries, sequential interval scan, 4-class result with confidence.
- Adds batch/sliding trigger modes, result acknowledge, busy/overflow reporting, and a 4th class TENSE (11).
- Sits between the note sequencer (load_new_note strobes) and the display/LED result logic.

---
 rtl/ai_emotion_pkg.sv | 27 ++
 rtl/ai_interval_feature_acc.sv | 61 ++++++
 rtl/ai_emotion_analyzer_param.sv | 246 ++++++++++++++++++++++++
 3 files changed

// File: rtl/ai_emotion_pkg.sv
// Shared types and constants for the melodic emotion analyser.
package ai_emotion_pkg;

  typedef enum logic [1:0] {
    EMO_NEUTRAL = 2'b00,
    EMO_HAPPY   = 2'b01,
    EMO_SAD     = 2'b10,
    EMO_TENSE   = 2'b11
  } emotion_e;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'b00,
    ST_SCAN   = 2'b01,
    ST_DECIDE = 2'b10
  } state_e;

  localparam logic MODE_BATCH   = 1'b0;
  localparam logic MODE_SLIDING = 1'b1;

  localparam logic [7:0] CONF_NEUTRAL = 8'h80;

  typedef struct packed {
    emotion_e   code;
    logic [7:0] conf;
  } result_t;

endpackage

// File: rtl/ai_interval_feature_acc.sv
// Interval classifier and feature counters for one note pair per step.
module ai_interval_feature_acc #(
  parameter int unsigned NOTE_W   = 6,
  parameter int unsigned CNT_W    = 4,
  parameter int unsigned LEAP_MIN = 6
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              clr,
  input  logic              step,
  input  logic [NOTE_W-1:0] note_cur,
  input  logic [NOTE_W-1:0] note_prev,
  output logic [CNT_W-1:0]  up_cnt,
  output logic [CNT_W-1:0]  down_cnt,
  output logic [CNT_W-1:0]  semi_cnt,
  output logic [CNT_W-1:0]  arp_cnt,
  output logic [CNT_W-1:0]  leap_cnt
);

  logic signed [NOTE_W:0] delta;
  logic [NOTE_W:0]        mag;
  logic                   is_up;
  logic                   is_down;
  logic                   is_semi;
  logic                   is_arp;
  logic                   is_leap;

  // Signed interval and its magnitude, one bit wider than the note code
  always_comb begin
    delta   = $signed({1'b0, note_cur}) - $signed({1'b0, note_prev});
    mag     = delta[NOTE_W] ? $unsigned(-delta) : $unsigned(delta);
    is_up   = !delta[NOTE_W] && (delta != '0);
    is_down = delta[NOTE_W];
    is_semi = (mag == (NOTE_W+1)'(1));
    is_arp  = (mag == (NOTE_W+1)'(3)) || (mag == (NOTE_W+1)'(4));
    is_leap = (32'(mag) >= LEAP_MIN);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      up_cnt   <= '0;
      down_cnt <= '0;
      semi_cnt <= '0;
      arp_cnt  <= '0;
      leap_cnt <= '0;
    end else if (clr) begin
      up_cnt   <= '0;
      down_cnt <= '0;
      semi_cnt <= '0;
      arp_cnt  <= '0;
      leap_cnt <= '0;
    end else if (step) begin
      up_cnt   <= up_cnt   + CNT_W'(is_up);
      down_cnt <= down_cnt + CNT_W'(is_down);
      semi_cnt <= semi_cnt + CNT_W'(is_semi);
      arp_cnt  <= arp_cnt  + CNT_W'(is_arp);
      leap_cnt <= leap_cnt + CNT_W'(is_leap);
    end
  end

endmodule

// File: rtl/ai_emotion_analyzer_param.sv
// Circular note window with sequential interval scan and 4-class emotion decision.
module ai_emotion_analyzer_param
  import ai_emotion_pkg::*;
#(
  parameter int unsigned NOTE_W     = 6,
  parameter int unsigned DEPTH      = 16,
  parameter int unsigned CONTOUR_TH = 4,
  parameter int unsigned LEAP_MIN   = 6,
  localparam int unsigned LOG2D     = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              enable_ai,
  input  logic              mode,
  input  logic              clear,
  input  logic [NOTE_W-1:0] note_played,
  input  logic              load_new_note,
  input  logic              result_ack,
  output logic [1:0]        emotion_code,
  output logic [7:0]        emotion_confidence,
  output logic              emotion_ready,
  output logic              buffer_full,
  output logic              busy,
  output logic              note_dropped,
  output logic [LOG2D:0]    fill_level
);

  localparam int unsigned FW    = LOG2D + 1;
  localparam int unsigned HALF  = DEPTH / 2;
  localparam int unsigned SHIFT = 8 - LOG2D;

  logic [NOTE_W-1:0] mem [DEPTH];
  logic [LOG2D-1:0]  wr_ptr;
  logic [LOG2D-1:0]  wr_ptr_p1;
  logic [LOG2D-1:0]  wr_ptr_next;
  logic [LOG2D-1:0]  scan_cnt;
  logic [LOG2D-1:0]  cur_idx;
  logic [LOG2D-1:0]  prev_idx;
  logic [NOTE_W-1:0] pend_note;
  logic              pend_valid;
  logic              dirty;
  logic              analysed;
  logic              scan_mode;

  state_e state;
  state_e state_next;
  logic   start;
  logic   step;
  logic   decide;

  logic              wr0_en;
  logic              wr1_en;
  logic [NOTE_W-1:0] wr0_data;
  logic [NOTE_W-1:0] wr1_data;
  logic              pend_load;
  logic              drop;
  logic [1:0]        n_wr;
  logic [FW:0]       fill_sum;
  logic [FW-1:0]     fill_next;

  logic [LOG2D-1:0] up_cnt;
  logic [LOG2D-1:0] down_cnt;
  logic [LOG2D-1:0] semi_cnt;
  logic [LOG2D-1:0] arp_cnt;
  logic [LOG2D-1:0] leap_cnt;
  result_t          res;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= ST_IDLE;
    else          state <= state_next;
  end

  // Next state and scan control; clear overrides everything
  always_comb begin
    state_next = state;
    start      = 1'b0;
    step       = 1'b0;
    decide     = 1'b0;
    case (state)
      ST_IDLE: begin
        if (enable_ai && buffer_full && ((mode == MODE_BATCH) ? !analysed : dirty)) begin
          start      = 1'b1;
          state_next = ST_SCAN;
        end
      end
      ST_SCAN: begin
        step = 1'b1;
        if (scan_cnt == LOG2D'(DEPTH - 1)) state_next = ST_DECIDE;
      end
      ST_DECIDE: begin
        decide     = 1'b1;
        state_next = ST_IDLE;
      end
      default: state_next = ST_IDLE;
    endcase
    if (clear) begin
      state_next = ST_IDLE;
      start      = 1'b0;
      step       = 1'b0;
      decide     = 1'b0;
    end
  end

  // Write steering: pending note first, then any same-cycle external load
  always_comb begin
    wr0_en    = 1'b0;
    wr1_en    = 1'b0;
    wr0_data  = note_played;
    wr1_data  = note_played;
    pend_load = 1'b0;
    drop      = 1'b0;
    if (!clear) begin
      if (state == ST_IDLE) begin
        if (pend_valid) begin
          wr0_en   = 1'b1;
          wr0_data = pend_note;
          wr1_en   = load_new_note;
        end else begin
          wr0_en = load_new_note;
        end
      end else if (load_new_note) begin
        if (pend_valid) drop = 1'b1;
        else            pend_load = 1'b1;
      end
    end
    n_wr        = 2'(wr0_en) + 2'(wr1_en);
    wr_ptr_p1   = wr_ptr + LOG2D'(1);
    wr_ptr_next = wr_ptr + LOG2D'(n_wr);
    fill_sum    = {1'b0, fill_level} + (FW+1)'(n_wr);
    fill_next   = (fill_sum >= (FW+1)'(DEPTH)) ? FW'(DEPTH) : fill_sum[FW-1:0];
  end

  always_ff @(posedge clk) begin
    if (wr0_en) mem[wr_ptr] <= wr0_data;
    if (wr1_en) mem[wr_ptr_p1] <= wr1_data;
  end

  // Window is only scanned when full, so the oldest entry sits at wr_ptr
  always_comb begin
    cur_idx  = wr_ptr + scan_cnt;
    prev_idx = cur_idx - LOG2D'(1);
  end

  ai_interval_feature_acc #(
    .NOTE_W   (NOTE_W),
    .CNT_W    (LOG2D),
    .LEAP_MIN (LEAP_MIN)
  ) u_acc (
    .clk       (clk),
    .reset_n   (reset_n),
    .clr       (start || clear),
    .step      (step),
    .note_cur  (mem[cur_idx]),
    .note_prev (mem[prev_idx]),
    .up_cnt    (up_cnt),
    .down_cnt  (down_cnt),
    .semi_cnt  (semi_cnt),
    .arp_cnt   (arp_cnt),
    .leap_cnt  (leap_cnt)
  );

  // Priority decision on the final counter values
  always_comb begin
    res.code = EMO_NEUTRAL;
    res.conf = CONF_NEUTRAL;
    if (32'(semi_cnt) >= HALF) begin
      res.code = EMO_NEUTRAL;
      res.conf = 8'(semi_cnt) << SHIFT;
    end else if (32'(leap_cnt) >= HALF) begin
      res.code = EMO_TENSE;
      res.conf = 8'(leap_cnt) << SHIFT;
    end else if (32'(arp_cnt) >= HALF) begin
      res.code = EMO_HAPPY;
      res.conf = 8'(arp_cnt) << SHIFT;
    end else if (32'(up_cnt) > 32'(down_cnt) + CONTOUR_TH) begin
      res.code = EMO_HAPPY;
      res.conf = 8'(up_cnt) << SHIFT;
    end else if (32'(down_cnt) > 32'(up_cnt) + CONTOUR_TH) begin
      res.code = EMO_SAD;
      res.conf = 8'(down_cnt) << SHIFT;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr             <= '0;
      fill_level         <= '0;
      buffer_full        <= 1'b0;
      pend_valid         <= 1'b0;
      pend_note          <= '0;
      dirty              <= 1'b0;
      analysed           <= 1'b0;
      scan_mode          <= MODE_BATCH;
      scan_cnt           <= '0;
      busy               <= 1'b0;
      note_dropped       <= 1'b0;
      emotion_ready      <= 1'b0;
      emotion_code       <= 2'b00;
      emotion_confidence <= 8'h00;
    end else begin
      busy         <= (state_next != ST_IDLE);
      note_dropped <= drop;
      if (clear) begin
        wr_ptr             <= '0;
        fill_level         <= '0;
        buffer_full        <= 1'b0;
        pend_valid         <= 1'b0;
        pend_note          <= '0;
        dirty              <= 1'b0;
        analysed           <= 1'b0;
        scan_cnt           <= '0;
        emotion_ready      <= 1'b0;
        emotion_code       <= 2'b00;
        emotion_confidence <= 8'h00;
      end else begin
        wr_ptr      <= wr_ptr_next;
        fill_level  <= fill_next;
        buffer_full <= (fill_next == FW'(DEPTH));
        if (pend_load) begin
          pend_valid <= 1'b1;
          pend_note  <= note_played;
        end else if (state == ST_IDLE) begin
          pend_valid <= 1'b0;
        end
        if (start)          dirty <= 1'b0;
        else if (n_wr != 0) dirty <= 1'b1;
        if (start) begin
          scan_mode <= mode;
          scan_cnt  <= LOG2D'(1);
        end else if (step) begin
          scan_cnt <= scan_cnt + LOG2D'(1);
        end
        // A fresh result wins over a same-cycle acknowledge
        if (decide) begin
          emotion_code       <= res.code;
          emotion_confidence <= res.conf;
          emotion_ready      <= 1'b1;
          if (scan_mode == MODE_BATCH) analysed <= 1'b1;
        end else if (result_ack) begin
          emotion_ready <= 1'b0;
        end
      end
    end
  end

endmodule
